// File: rtl/tap_stream_fir.sv
// tap_stream_fir: double-buffered tap bank feeding a serial MAC FIR.
// Ports: clk/reset (sync, active-high); tapValid/tapNum/tapCoeff write
//   the shadow bank; coeffsLoaded goes high after the first commit;
//   sampleValid/sampleIn/sampleReady accept audio samples;
//   outValid pulses for one cycle with the saturated sampleOut.
module tap_stream_fir #(
    parameter int NTAPS = 16,
    parameter int DW    = 16,
    parameter int CW    = 16,
    parameter int AW    = 32 + $clog2(NTAPS)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 tapValid,
    input  logic [7:0]           tapNum,
    input  logic signed [CW-1:0] tapCoeff,
    output logic                 coeffsLoaded,
    input  logic                 sampleValid,
    input  logic signed [DW-1:0] sampleIn,
    output logic                 sampleReady,
    output logic                 outValid,
    output logic signed [DW-1:0] sampleOut
);

    localparam int IW = (NTAPS > 1) ? $clog2(NTAPS) : 1;
    localparam int PW = CW + DW;
    localparam logic [7:0]    LAST_TAP = 8'(NTAPS - 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(NTAPS - 1);
    localparam logic [DW-1:0] POS_MAX  = {1'b0, {(DW-1){1'b1}}};
    localparam logic [DW-1:0] NEG_MIN  = {1'b1, {(DW-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        DONE
    } state_t;

    state_t               state_q, state_d;
    logic signed [CW-1:0] shadow_q [NTAPS];
    logic signed [CW-1:0] shadow_d [NTAPS];
    logic signed [CW-1:0] active_q [NTAPS];
    logic signed [CW-1:0] active_d [NTAPS];
    logic signed [DW-1:0] delay_q  [NTAPS];
    logic signed [DW-1:0] delay_d  [NTAPS];
    logic signed [AW-1:0] acc_q, acc_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic                 commit_pending_q, commit_pending_d;
    logic                 loaded_q, loaded_d;
    logic                 out_valid_q, out_valid_d;
    logic signed [DW-1:0] sample_out_q, sample_out_d;

    logic                 tap_write;
    logic                 tap_last;
    logic                 commit;
    logic                 ready;
    logic signed [PW-1:0] prod;
    logic signed [AW-1:0] shifted;
    logic [AW-DW:0]       top_bits;
    logic                 fits;
    logic [DW-1:0]        sat_val;

    assign tap_write = tapValid && (tapNum <= LAST_TAP);
    assign tap_last  = tapValid && (tapNum == LAST_TAP);
    assign commit    = (state_q == IDLE) && commit_pending_q;
    assign ready     = !reset && (state_q == IDLE) && !commit_pending_q;

    assign prod = active_q[idx_q] * delay_q[idx_q];

    // Drop the Q1.15 fraction; the value fits DW bits only when every
    // bit above the DW-1 position matches the sign.
    assign shifted  = acc_q >>> (CW - 1);
    assign top_bits = shifted[AW-1:DW-1];
    assign fits     = (&top_bits) | ~(|top_bits);
    assign sat_val  = fits ? shifted[DW-1:0]
                    : (shifted[AW-1] ? NEG_MIN : POS_MAX);

    always_comb begin
        state_d      = state_q;
        shadow_d     = shadow_q;
        active_d     = active_q;
        delay_d      = delay_q;
        acc_d        = acc_q;
        idx_d        = idx_q;
        loaded_d     = loaded_q;
        out_valid_d  = 1'b0;
        sample_out_d = sample_out_q;

        if (tap_write) begin
            shadow_d[tapNum[IW-1:0]] = tapCoeff;
        end

        unique case (state_q)
            IDLE: begin
                if (commit) begin
                    active_d = shadow_q;
                    loaded_d = 1'b1;
                end else if (sampleValid) begin
                    for (int i = NTAPS - 1; i > 0; i--) begin
                        delay_d[i] = delay_q[i-1];
                    end
                    delay_d[0] = sampleIn;
                    acc_d      = '0;
                    idx_d      = '0;
                    state_d    = MAC;
                end
            end
            MAC: begin
                acc_d = acc_q + AW'(prod);
                idx_d = idx_q + 1'b1;
                if (idx_q == LAST_IDX) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                sample_out_d = sat_val;
                out_valid_d  = 1'b1;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // A last-tap write in the commit cycle re-arms the next commit.
        commit_pending_d = tap_last | (commit_pending_q & ~commit);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= IDLE;
            shadow_q         <= '{default: '0};
            active_q         <= '{default: '0};
            delay_q          <= '{default: '0};
            acc_q            <= '0;
            idx_q            <= '0;
            commit_pending_q <= 1'b0;
            loaded_q         <= 1'b0;
            out_valid_q      <= 1'b0;
            sample_out_q     <= '0;
        end else begin
            state_q          <= state_d;
            shadow_q         <= shadow_d;
            active_q         <= active_d;
            delay_q          <= delay_d;
            acc_q            <= acc_d;
            idx_q            <= idx_d;
            commit_pending_q <= commit_pending_d;
            loaded_q         <= loaded_d;
            out_valid_q      <= out_valid_d;
            sample_out_q     <= sample_out_d;
        end
    end

    assign coeffsLoaded = loaded_q;
    assign sampleReady  = ready;
    assign outValid     = out_valid_q;
    assign sampleOut    = sample_out_q;

endmodule

// File: tb/tb_tap_stream_fir.sv
// tb_tap_stream_fir: directed + random stimulus for tap_stream_fir
// (NTAPS=4) against a transaction-level FIR model.
module tb_tap_stream_fir;

    localparam int NT = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        tapValid = 1'b0;
    logic [7:0]  tapNum = '0;
    logic [15:0] tapCoeff = '0;
    logic        coeffsLoaded;
    logic        sampleValid = 1'b0;
    logic [15:0] sampleIn = '0;
    logic        sampleReady;
    logic        outValid;
    logic [15:0] sampleOut;

    tap_stream_fir #(.NTAPS(NT)) dut (
        .clk         (clk),
        .reset       (reset),
        .tapValid    (tapValid),
        .tapNum      (tapNum),
        .tapCoeff    (tapCoeff),
        .coeffsLoaded(coeffsLoaded),
        .sampleValid (sampleValid),
        .sampleIn    (sampleIn),
        .sampleReady (sampleReady),
        .outValid    (outValid),
        .sampleOut   (sampleOut)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    bit started = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, act, req, $time);
        end
    endtask

    // Transaction-level model: banks as int arrays, sample history,
    // a busy countdown standing in for the compute time.
    int  m_shadow [NT];
    int  m_active [NT];
    int  m_hist   [NT];
    bit  m_pending;
    bit  m_loaded;
    int  m_busy;
    int  m_y;
    bit  exp_valid;
    int  exp_out;

    function automatic int fir_out();
        longint s = 0;
        for (int i = 0; i < NT; i++) begin
            s += longint'(m_active[i]) * longint'(m_hist[i]);
        end
        s = s >>> 15;
        if (s > 32767) s = 32767;
        if (s < -32768) s = -32768;
        return int'(s);
    endfunction

    always @(posedge clk) begin
        cyc++;
        started = 1;
        if (reset) begin
            for (int i = 0; i < NT; i++) begin
                m_shadow[i] = 0;
                m_active[i] = 0;
                m_hist[i]   = 0;
            end
            m_pending = 0;
            m_loaded  = 0;
            m_busy    = 0;
            exp_valid = 0;
            exp_out   = 0;
        end else begin
            exp_valid = 0;
            if (m_busy > 0) begin
                m_busy--;
                if (m_busy == 0) begin
                    exp_valid = 1;
                    exp_out   = m_y;
                end
            end else if (m_pending) begin
                m_active  = m_shadow;
                m_loaded  = 1;
                m_pending = 0;
            end else if (sampleValid) begin
                for (int i = NT - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
                m_hist[0] = int'($signed(sampleIn));
                m_y    = fir_out();
                m_busy = NT + 1;
            end
            if (tapValid && int'(tapNum) < NT) begin
                m_shadow[tapNum] = int'($signed(tapCoeff));
                if (int'(tapNum) == NT - 1) m_pending = 1;
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("outValid", {31'b0, outValid}, {31'b0, exp_valid});
            chk("sampleOut", {16'b0, sampleOut}, {16'b0, exp_out[15:0]});
            chk("coeffsLoaded", {31'b0, coeffsLoaded}, {31'b0, m_loaded});
            if (!reset) begin
                chk("sampleReady", {31'b0, sampleReady},
                    {31'b0, (m_busy == 0) && !m_pending});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_tap(input logic [7:0] n, input logic [15:0] c);
        tapValid = 1'b1;
        tapNum   = n;
        tapCoeff = c;
        tick();
        tapValid = 1'b0;
    endtask

    task automatic send_sample(input logic [15:0] v, output int acc_cyc);
        bit got = 0;
        acc_cyc     = 0;
        sampleValid = 1'b1;
        sampleIn    = v;
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge clk);
            if (sampleReady) begin
                got     = 1;
                acc_cyc = cyc;
            end
            tick();
        end
        sampleValid = 1'b0;
        if (!got) chk("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_out(output logic [15:0] v, output int oc);
        bit got = 0;
        v  = '0;
        oc = 0;
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge clk);
            if (outValid) begin
                got = 1;
                v   = sampleOut;
                oc  = cyc;
            end
        end
        if (!got) chk("out_timeout", 32'd0, 32'd1);
    endtask

    logic [15:0] y;
    int          a, o, pulses;
    logic [15:0] imp_in  [5];
    logic [15:0] imp_exp [5];
    logic [15:0] sat_out [8];
    bit          clr;
    int          r;

    initial begin
        imp_in  = '{16'h4000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
        imp_exp = '{16'h2000, 16'h1000, 16'h0800, 16'h0400, 16'h0000};

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_ready", {31'b0, sampleReady}, 32'd1);
        chk("rst_loaded", {31'b0, coeffsLoaded}, 32'd0);
        chk("rst_out", {16'b0, sampleOut}, 32'd0);
        tick();

        // Unloaded bank.
        send_sample(16'h1234, a);
        wait_out(y, o);
        chk("unloaded_out", {16'b0, y}, 32'd0);
        chk("unloaded_loaded", {31'b0, coeffsLoaded}, 32'd0);
        tick();

        reset = 1'b1;
        tick();
        reset = 1'b0;

        // Impulse, with out-of-range writes among the tap loads.
        write_tap(8'd0, 16'h4000);
        write_tap(8'd4, 16'h7FFF);
        write_tap(8'hFF, 16'h7FFF);
        tick();
        @(negedge clk);
        chk("oor_no_commit", {31'b0, coeffsLoaded}, 32'd0);
        chk("oor_ready", {31'b0, sampleReady}, 32'd1);
        tick();
        write_tap(8'd1, 16'h2000);
        write_tap(8'd2, 16'h1000);
        write_tap(8'd3, 16'h0800);
        tick();
        chk("imp_loaded", {31'b0, coeffsLoaded}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            send_sample(imp_in[i], a);
            wait_out(y, o);
            chk("imp_out", {16'b0, y}, {16'b0, imp_exp[i]});
            chk("imp_latency", o - a, 32'd6);
            tick();
        end

        // Saturation.
        for (int i = 0; i < NT; i++) write_tap(8'(i), 16'h7FFF);
        for (int i = 0; i < 8; i++) begin
            send_sample(i < 4 ? 16'h7FFF : 16'h8000, a);
            wait_out(sat_out[i], o);
            tick();
        end
        chk("sat_pos", {16'b0, sat_out[3]}, 32'h7FFF);
        chk("sat_neg", {16'b0, sat_out[7]}, 32'h8000);

        // Double buffering: new all-zero set written during MAC.
        send_sample(16'h0100, a);
        for (int i = 0; i < NT; i++) write_tap(8'(i), 16'h0000);
        wait_out(y, o);
        chk("dbuf_old_coeffs", {16'b0, y}, 32'h8000);
        chk("dbuf_commit_low", {31'b0, sampleReady}, 32'd0);
        @(negedge clk);
        chk("dbuf_ready_back", {31'b0, sampleReady}, 32'd1);
        tick();
        send_sample(16'h0200, a);
        wait_out(y, o);
        chk("dbuf_new_zero", {16'b0, y}, 32'h0000);
        tick();

        // Commit collision: tap 3 written again in the commit cycle.
        for (int i = 0; i < 3; i++) write_tap(8'(i), 16'h1000);
        tapValid = 1'b1;
        tapNum   = 8'd3;
        tapCoeff = 16'h1000;
        @(negedge clk);
        chk("coll_ready_a", {31'b0, sampleReady}, 32'd1);
        tick();
        tapCoeff = 16'h2000;
        @(negedge clk);
        chk("coll_commit1", {31'b0, sampleReady}, 32'd0);
        tick();
        tapValid = 1'b0;
        @(negedge clk);
        chk("coll_commit2", {31'b0, sampleReady}, 32'd0);
        @(negedge clk);
        chk("coll_ready_d", {31'b0, sampleReady}, 32'd1);
        tick();
        send_sample(16'h4000, a);
        wait_out(y, o);
        chk("coll_out", {16'b0, y}, 32'hE860);
        tick();

        // Reset two cycles into MAC.
        send_sample(16'h3000, a);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk("mrst_loaded", {31'b0, coeffsLoaded}, 32'd0);
        chk("mrst_out", {16'b0, sampleOut}, 32'd0);
        chk("mrst_ready", {31'b0, sampleReady}, 32'd1);
        pulses = outValid ? 1 : 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (outValid) pulses++;
        end
        chk("mrst_no_pulse", pulses, 32'd0);
        tick();
        send_sample(16'h1111, a);
        wait_out(y, o);
        chk("mrst_after", {16'b0, y}, 32'h0000);
        tick();

        // Random traffic against the model.
        for (int c = 0; c < 800; c++) begin
            tapValid = ($urandom_range(0, 3) == 0);
            r = $urandom_range(0, 9);
            tapNum = (r < 7) ? 8'(r % NT) : ((r == 7) ? 8'd4 : 8'hFF);
            if ($urandom_range(0, 1) == 0) begin
                tapCoeff = 16'($urandom);
            end else begin
                tapCoeff = 16'($urandom_range(0, 8191)) - 16'd4096;
            end
            if (!sampleValid && $urandom_range(0, 2) == 0) begin
                sampleValid = 1'b1;
                sampleIn    = 16'($urandom);
            end
            reset = (c == 400);
            @(negedge clk);
            clr = sampleValid && sampleReady;
            tick();
            if (clr) sampleValid = 1'b0;
        end
        tapValid    = 1'b0;
        sampleValid = 1'b0;
        reset       = 1'b0;
        repeat (12) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tap_stream_fir.md
Name: tap_stream_fir

Overview:
- Consumer end of the equalizer tap-coefficient stream. Accepts (tap number, coefficient) writes from the tap generator into a shadow bank.
- When the final tap of a set arrives, it commits the set atomically to an active bank.
- Runs a serial multiply-accumulate FIR over incoming audio samples using the active bank.
- Sits between the tap generator and the audio output path.

Parameters:
- NTAPS, 16: number of filter taps; tap indices are 0..NTAPS-1.
- DW, 16: signed sample width, input and output.
- CW, 16: signed coefficient width, Q1.15 format.
- AW, 32+$clog2(NTAPS): accumulator width.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- tapValid  in  1  coefficient write strobe.
- tapNum  in  8  tap index of the write.
- tapCoeff  in  CW  signed Q1.15 coefficient.
- coeffsLoaded  out  1  sticky; high once the first full set has been committed.
- sampleValid  in  1  input sample offered.
- sampleIn  in  DW  signed input sample.
- sampleReady  out  1  block can accept a sample this cycle.
- outValid  out  1  one-cycle pulse marking a valid sampleOut.
- sampleOut  out  DW  signed filtered sample, held between pulses.

Behaviour:
- Reset clears:
  - shadow bank, active bank and delay line to 0;
  - accumulator and tap counter to 0;
  - commitPending to 0;
  - FSM to IDLE.
- Output values during reset: coeffsLoaded=0, outValid=0, sampleOut=0. sampleReady=1 from the first cycle after reset deasserts.
- Reset mid-MAC aborts the computation; no outValid is produced for that sample.
- Coefficient writes:
  - On tapValid with tapNum<NTAPS, shadow[tapNum] <= tapCoeff.
  - Writes with tapNum>=NTAPS are ignored entirely, including for commit purposes.
  - Repeated writes to the same index before commit: the last write wins.
  - A valid write with tapNum==NTAPS-1 sets commitPending.
  - Writes land in the shadow bank in any FSM state and never alter the active bank directly.
- Commit:
  - Occurs in IDLE when commitPending=1. In that cycle, active <= shadow (all taps), commitPending cleared, coeffsLoaded <= 1.
  - sampleReady=0 during the commit cycle; the sample is accepted on a later cycle.
  - If a write with tapNum==NTAPS-1 occurs in the commit cycle, the write still lands in shadow and commitPending is re-set (set dominates clear).
- Before the first commit the active bank is all zero, so the output is 0.
- FSM IDLE:
  - sampleReady = ~commitPending.
  - On sampleValid && sampleReady: delay line shifts (delay[0] <= sampleIn, delay[i] <= delay[i-1]); acc <= 0; idx <= 0; go to MAC.
- FSM MAC:
  - sampleReady=0.
  - Each cycle: acc <= acc + active[idx]*delay[idx], a signed CW x DW product sign-extended to AW; idx <= idx+1.
  - After the idx==NTAPS-1 term, go to DONE. MAC lasts exactly NTAPS cycles.
- FSM DONE:
  - sampleReady=0.
  - sampleOut <= saturate(acc >>> 15) to DW bits: clamp to 0x7FFF / 0x8000 on overflow; arithmetic shift truncates toward -inf.
  - outValid=1 for one cycle; return to IDLE.
- Latency: a sample accepted at edge T gives outValid high in cycle T+NTAPS+1.
- Throughput: one sample per NTAPS+2 cycles, or +1 cycle when a commit intervenes.
- sampleValid while sampleReady=0 is not consumed; the source must hold the sample.

Test Plan:
1. Impulse (NTAPS=4):
   - Stimulus: load taps 0x4000,0x2000,0x1000,0x0800 with tapNum 0..3; then samples 0x4000,0,0,0,0.
   - Required: outputs 0x2000,0x1000,0x0800,0x0400,0x0000; coeffsLoaded=1 after the commit; each outValid exactly 6 cycles after acceptance.
2. Saturation:
   - Stimulus: all taps 0x7FFF; four samples 0x7FFF, then four samples 0x8000.
   - Required: fourth output 0x7FFF (clamped); eighth output 0x8000 (clamped).
3. Unloaded and out-of-range:
   - Stimulus: sample 0x1234 sent before any tap write.
   - Required: output 0x0000 with coeffsLoaded=0.
   - Stimulus: tap writes with tapNum=4 and tapNum=0xFF.
   - Required: no commit and no bank change.
4. Double buffering:
   - Stimulus: during MAC of a sample, write a new set with all taps 0.
   - Required: the current output still uses the old coefficients; sampleReady is low for exactly one commit cycle in the next IDLE; the following output is 0x0000.
5. Commit collision:
   - Stimulus: a tapNum=3 write coincides with the commit cycle.
   - Required: the write is kept in shadow, commitPending=1 afterward, and a second commit follows.
6. Reset mid-MAC:
   - Stimulus: assert reset two cycles into MAC.
   - Required: no outValid pulse; coeffsLoaded=0, sampleOut=0, and sampleReady=1 the cycle after reset falls; a subsequent sample yields 0x0000.
